nvme_rq_arbiter: RTL
====================

Name: nvme_rq_arbiter

Overview:
- Shares the single ioq_rq request channel between NUM_REQ upstream requesters, e.g. SQ-entry fetch, PRP/data fetch and doorbell writes.
- Arbitrates round-robin among requesters.
- Allocates 6-bit PCIe tags for non-posted reads from a free-tag pool.
- Returns tags to the pool when the RC path reports the final completion for a tag.
- Sits between the IO-queue logic and nvme_pcie_rq, in the user_clk domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TAG_W, 6, tag width; pool holds 2**TAG_W tags.
- RD_TYPE, 4'b0000, reqType code for memory read (non-posted, needs a tag).
- WR_TYPE, 4'b0001, reqType code for memory write (posted, no tag).

Ports:
- user_clk  in  1  clock.
- user_reset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_type  in  NUM_REQ*4  request type, slice i = [4i+3:4i].
- req_addr  in  NUM_REQ*64  byte address.
- req_data  in  NUM_REQ*128  write payload.
- req_byten  in  NUM_REQ*8  first/last DW byte enables.
- req_dword  in  NUM_REQ*11  DW count.
- req_ack  out  NUM_REQ  one-cycle accept pulse to requester i.
- req_tag  out  TAG_W  tag assigned to the request being acked; valid with req_ack.
- ioq_rq_valid  out  1  request to nvme_pcie_rq.
- ioq_rq_reqType  out  4
- ioq_rq_addr  out  64
- ioq_rq_data  out  128
- ioq_rq_byten  out  8
- ioq_rq_dword  out  11
- ioq_rq_tag  out  TAG_W
- rq_ioq_ack  in  1  downstream accept.
- cpl_done_valid  in  1  final completion received for a tag.
- cpl_done_tag  in  TAG_W  tag to free.
- tags_outstanding  out  TAG_W+1  count of allocated tags.
- tag_err  out  1  sticky: a tag was freed while already free.

Behaviour:
- Reset: all ioq_rq_* outputs, req_ack, req_tag, tag_err = 0. Free bitmap all ones. tags_outstanding = 0. RR pointer = 0. State = IDLE. Reset mid-transaction drops ioq_rq_valid immediately and forgets all outstanding tags.
- FSM IDLE -> ISSUE.
- IDLE: compute eligible[i] = req_valid[i] && (req_type[i] != RD_TYPE || pool not empty).
  - If any requester is eligible, pick the first eligible index at or after the RR pointer (wrapping).
  - Register its fields into the ioq_rq_* outputs.
  - If it is a read, set ioq_rq_tag = lowest-index free tag and clear that bitmap bit. Writes drive tag 0 and allocate nothing.
  - Set ioq_rq_valid = 1, move to ISSUE.
  - Latency from req_valid to ioq_rq_valid: 1 cycle.
- ISSUE: hold all outputs stable until rq_ioq_ack.
  - On ack: ioq_rq_valid = 0, pulse req_ack[granted] in the same cycle, with req_tag = issued tag.
  - RR pointer becomes granted+1 mod NUM_REQ. Return to IDLE.
  - Minimum spacing between grants: 2 cycles.
- Requesters hold their fields stable until req_ack. Dropping req_valid before req_ack is illegal; the arbiter has already latched the fields and completes the request anyway.
- Free: on cpl_done_valid, set bitmap[cpl_done_tag].
  - If that bit was already set, leave it set and set tag_err (cleared only by reset).
  - Allocation and free in the same cycle are both applied. tags_outstanding = popcount(~bitmap), maintained as a ±1 counter, net 0 when both occur.
- Pool empty (64 outstanding): reads are ineligible and writes still proceed, so a blocked read never stalls writes. A freed tag is usable in the IDLE cycle after the free.
- The free in the same cycle as an empty-pool check is not visible to that check (registered bitmap).

Decomposition:
- Shared package nvme_pcie_pkg holds RD_TYPE/WR_TYPE codes, TAG_W and the request field widths (64/128/8/11).
- One sub-module nvme_tag_pool: free bitmap, lowest-free priority encoder, counter and tag_err.
- The round-robin pick stays inline.

Test Plan:
- Single write: req_valid[1]=1, type WR_TYPE, addr 0x1000_0008, data 0xDEAD…; rq_ioq_ack two cycles after ioq_rq_valid -> ioq_rq_valid rises 1 cycle after req_valid, fields match, req_ack[1] pulses with rq_ioq_ack, tags_outstanding stays 0.
- Round-robin: all three requesters hold writes, ack every cycle it is offered -> grant order 0,1,2,0,1,2 and each req_ack pulse is one cycle.
- Tag allocation: 3 reads back-to-back -> tags 0,1,2 issued, tags_outstanding = 3. cpl_done_tag=1 then a read -> tag 1 reused.
- Pool exhaustion: 64 reads outstanding, requester 0 read pending, requester 2 write pending -> write issued, read held. cpl_done_tag=37 -> read issued next IDLE with tag 37.
- Simultaneous alloc/free in the same cycle as ack with tags_outstanding=10 -> count stays 10. Double-free of tag 5 -> tag_err=1 and the bitmap is unchanged.
- Assert user_reset while in ISSUE with 20 tags outstanding -> ioq_rq_valid=0 asynchronously, tags_outstanding=0, the next read gets tag 0.

Source files
------------

// File: rtl/nvme_pcie_pkg.sv
// Shared constants for the NVMe PCIe request path: request type codes,
// tag width, request field widths and the arbiter state encoding.
package nvme_pcie_pkg;

    localparam int TAG_WIDTH = 6;
    localparam int TYPE_W    = 4;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 128;
    localparam int BYTEN_W   = 8;
    localparam int DWORD_W   = 11;

    localparam logic [TYPE_W-1:0] RD_TYPE_CODE = 4'b0000;
    localparam logic [TYPE_W-1:0] WR_TYPE_CODE = 4'b0001;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/nvme_tag_pool.sv
// Free-tag pool for non-posted reads: free bitmap, lowest-free encoder,
// outstanding counter and a sticky flag for frees of tags already free.
module nvme_tag_pool
    import nvme_pcie_pkg::*;
#(
    parameter int TAG_W = TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    output logic [TAG_W-1:0] o_alloc_tag,
    output logic             o_empty,
    input  logic             i_free_valid,
    input  logic [TAG_W-1:0] i_free_tag,
    output logic [TAG_W:0]   o_outstanding,
    output logic             o_tag_err
);

    localparam int NUM_TAGS = 2 ** TAG_W;

    logic [NUM_TAGS-1:0] r_free_map;
    logic [NUM_TAGS-1:0] w_free_map_nxt;
    logic [TAG_W:0]      r_count;
    logic                r_tag_err;
    logic                w_free_ok;

    // Scanning downward leaves the lowest set index as the result.
    always_comb begin
        o_alloc_tag = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (r_free_map[t]) begin
                o_alloc_tag = TAG_W'(t);
            end
        end
    end

    assign o_empty   = ~|r_free_map;
    assign w_free_ok = i_free_valid && !r_free_map[i_free_tag];

    always_comb begin
        w_free_map_nxt = r_free_map;
        if (i_alloc) begin
            w_free_map_nxt[o_alloc_tag] = 1'b0;
        end
        if (w_free_ok) begin
            w_free_map_nxt[i_free_tag] = 1'b1;
        end
    end

    // A double free leaves the count alone, so it always equals the cleared bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free_map <= '1;
            r_count    <= '0;
            r_tag_err  <= 1'b0;
        end else begin
            r_free_map <= w_free_map_nxt;
            if (i_alloc && !w_free_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!i_alloc && w_free_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (i_free_valid && r_free_map[i_free_tag]) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign o_outstanding = r_count;
    assign o_tag_err     = r_tag_err;

endmodule

// File: rtl/nvme_rq_arbiter.sv
// Round-robin arbiter sharing the ioq_rq request channel between requesters;
// reads are stamped with a PCIe tag drawn from nvme_tag_pool.
module nvme_rq_arbiter
    import nvme_pcie_pkg::*;
#(
    parameter int                NUM_REQ = 3,
    parameter int                TAG_W   = TAG_WIDTH,
    parameter logic [TYPE_W-1:0] RD_TYPE = RD_TYPE_CODE
) (
    input  logic                         user_clk,
    input  logic                         user_reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*TYPE_W-1:0]    req_type,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*BYTEN_W-1:0]   req_byten,
    input  logic [NUM_REQ*DWORD_W-1:0]   req_dword,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [TAG_W-1:0]             req_tag,
    output logic                         ioq_rq_valid,
    output logic [TYPE_W-1:0]            ioq_rq_reqType,
    output logic [ADDR_W-1:0]            ioq_rq_addr,
    output logic [DATA_W-1:0]            ioq_rq_data,
    output logic [BYTEN_W-1:0]           ioq_rq_byten,
    output logic [DWORD_W-1:0]           ioq_rq_dword,
    output logic [TAG_W-1:0]             ioq_rq_tag,
    input  logic                         rq_ioq_ack,
    input  logic                         cpl_done_valid,
    input  logic [TAG_W-1:0]             cpl_done_tag,
    output logic [TAG_W:0]               tags_outstanding,
    output logic                         tag_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_grant;
    logic [PTR_W-1:0]   w_pick;
    logic               w_found;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_pool_empty;
    logic               w_issue;
    logic               w_done;
    logic               w_alloc;
    logic [TAG_W-1:0]   w_free_tag;
    logic [TYPE_W-1:0]  w_pick_type;

    // A read with no tag available must not block other requesters.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_valid[i] &&
                        ((req_type[TYPE_W*i +: TYPE_W] != RD_TYPE) || !w_pool_empty);
        end
    end

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'(idx);
            end
        end
    end

    assign w_pick_type = req_type[TYPE_W*w_pick +: TYPE_W];
    assign w_alloc     = w_issue && (w_pick_type == RD_TYPE);

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        req_ack     = '0;
        req_tag     = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (rq_ioq_ack) begin
                    w_done      = 1'b1;
                    req_ack     = NUM_REQ'(1) << r_grant;
                    req_tag     = ioq_rq_tag;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Fields are captured once at grant and held until the downstream ack.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            ioq_rq_valid   <= 1'b0;
            ioq_rq_reqType <= '0;
            ioq_rq_addr    <= '0;
            ioq_rq_data    <= '0;
            ioq_rq_byten   <= '0;
            ioq_rq_dword   <= '0;
            ioq_rq_tag     <= '0;
            r_grant        <= '0;
            r_rr_ptr       <= '0;
        end else if (w_issue) begin
            ioq_rq_valid   <= 1'b1;
            ioq_rq_reqType <= w_pick_type;
            ioq_rq_addr    <= req_addr[ADDR_W*w_pick +: ADDR_W];
            ioq_rq_data    <= req_data[DATA_W*w_pick +: DATA_W];
            ioq_rq_byten   <= req_byten[BYTEN_W*w_pick +: BYTEN_W];
            ioq_rq_dword   <= req_dword[DWORD_W*w_pick +: DWORD_W];
            ioq_rq_tag     <= w_alloc ? w_free_tag : '0;
            r_grant        <= w_pick;
        end else if (w_done) begin
            ioq_rq_valid <= 1'b0;
            r_rr_ptr     <= (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    nvme_tag_pool #(
        .TAG_W (TAG_W)
    ) u_tag_pool (
        .clk           (user_clk),
        .rst           (user_reset),
        .i_alloc       (w_alloc),
        .o_alloc_tag   (w_free_tag),
        .o_empty       (w_pool_empty),
        .i_free_valid  (cpl_done_valid),
        .i_free_tag    (cpl_done_tag),
        .o_outstanding (tags_outstanding),
        .o_tag_err     (tag_err)
    );

endmodule
